// File: rtl/muldiv_pkg.sv
// muldiv_pkg: RV32M op encodings, sequencer states and op-class helpers
package muldiv_pkg;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } muldiv_op_e;
  typedef enum logic [1:0] {IDLE, CALC, DONE} muldiv_state_e;
  function automatic logic is_div(muldiv_op_e op);
    return op[2];
  endfunction
  function automatic logic is_signed_a(muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction
  function automatic logic is_signed_b(muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction
endpackage

// File: rtl/muldiv_dpath.sv
// muldiv_dpath: shift-add multiply / restoring divide datapath with sign fix-up.
// MULDIV_EARLY_OUT_EN: flag multiplies whose remaining multiplier bits are all zero.
module muldiv_dpath import muldiv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            init_i,
  input  logic            step_i,
  input  logic            finish_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            fast_o,
  output logic            mz_o,
  output logic [XLEN-1:0] result_o
);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  muldiv_op_e op;
  logic sa, sb, div0, ovf, ok;
  logic [XLEN-1:0] a_mag, b_mag, rem, quo, rem_f, quo_f, res;
  logic [XLEN:0] tmp, diff;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [XLEN-1:0] b_q, b_d;
  logic sa_q, sa_d, neg_q, neg_d;
  assign op     = muldiv_op_e'(op_i);
  assign sa     = is_signed_a(op) & rs1_i[XLEN-1];
  assign sb     = is_signed_b(op) & rs2_i[XLEN-1];
  assign a_mag  = sa ? -rs1_i : rs1_i;
  assign b_mag  = sb ? -rs2_i : rs2_i;
  assign div0   = is_div(op) & (rs2_i == '0);
  assign ovf    = is_div(op) & is_signed_a(op) & (rs1_i == MIN) & (&rs2_i);
  assign fast_o = div0 | ovf;
  assign rem    = acc_q[2*XLEN-1:XLEN];
  assign quo    = acc_q[XLEN-1:0];
  assign tmp    = {rem, quo[XLEN-1]};
  assign diff   = tmp - {1'b0, b_q};
  assign ok     = ~diff[XLEN];
`ifdef MULDIV_EARLY_OUT_EN
  assign mz_o = ~is_div(op) & ~|b_q[XLEN-1:1];
`else
  assign mz_o = 1'b0;
`endif
  // Special divides preload the final quotient/remainder with signs cleared,
  // so the common fix-up at DONE passes them through untouched.
  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    b_d     = b_q;
    sa_d    = sa_q;
    neg_d   = neg_q;
    if (init_i) begin
      acc_d   = !is_div(op) ? '0 : div0 ? {rs1_i, {XLEN{1'b1}}} : ovf ? {{XLEN{1'b0}}, MIN} : {{XLEN{1'b0}}, a_mag};
      mcand_d = {{XLEN{1'b0}}, a_mag};
      b_d     = b_mag;
      sa_d    = sa & ~fast_o;
      neg_d   = (sa ^ sb) & ~fast_o;
    end else if (step_i) begin
      if (is_div(op)) begin
        acc_d = {ok ? diff[XLEN-1:0] : tmp[XLEN-1:0], quo[XLEN-2:0], ok};
      end else begin
        acc_d   = acc_q + (b_q[0] ? mcand_q : '0);
        mcand_d = mcand_q << 1;
        b_d     = b_q >> 1;
      end
    end
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      acc_q   <= '0;
      mcand_q <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      neg_q   <= neg_d;
    end
  end
  assign prod     = neg_q ? -acc_q : acc_q;
  assign quo_f    = neg_q ? -quo : quo;
  assign rem_f    = sa_q ? -rem : rem;
  assign res      = is_div(op) ? (op[1] ? rem_f : quo_f) : (op == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  assign result_o = finish_i ? res : '0;
endmodule

// File: rtl/execute_muldiv_ctl.sv
// execute_muldiv_ctl: RV32M multiply/divide sequencer for the execute stage.
// MULDIV_EARLY_OUT_EN: multiplies may leave CALC once the multiplier is exhausted.
module execute_muldiv_ctl import muldiv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            start_v_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_v_i,
  output logic            busy_o,
  output logic            result_v_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN);
  muldiv_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic accept, init, step, finish, fast, mz;
  assign accept = start_v_i & ~flush_v_i;
  assign op_d   = (state_q == IDLE && accept) ? op_i : op_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    init    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        init    = 1'b1;
        state_d = fast ? DONE : CALC;
      end
      CALC: begin
        step    = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(XLEN-1) || mz) ? DONE : CALC;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_v_i) state_d = IDLE;
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end
  assign finish     = (state_q == DONE) & ~flush_v_i;
  assign result_v_o = finish;
  // Gated by reset so the stall request drops the instant reset asserts.
  assign busy_o     = reset_n_i & (((state_q == IDLE) & accept) | (state_q == CALC));
  muldiv_dpath #(.XLEN(XLEN)) u_dpath (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .init_i    (init),
    .step_i    (step),
    .finish_i  (finish),
    .op_i      (op_d),
    .rs1_i     (rs1_i),
    .rs2_i     (rs2_i),
    .fast_o    (fast),
    .mz_o      (mz),
    .result_o  (result_o)
  );
endmodule
